// File: rtl/sled_scan.sv
// sled_scan: NUM_DIG-digit multiplexed 7-seg driver with hex up/down counter.
// Ports: clock, rst_n, load/load_val, cnt_en, up_dn, dp_in -> value, seg, dig.
// Optional macro SLED_LZB_EN enables leading-zero blanking.
module sled_scan #(
  parameter int unsigned NUM_DIG     = 4,
  parameter int unsigned SCAN_DIV    = 50000,
  parameter int unsigned CNT_DIV     = 25000000,
  parameter int unsigned DIG_ACT_LOW = 1
) (
  input  logic                   clock,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic [4*NUM_DIG-1:0]   load_val,
  input  logic                   cnt_en,
  input  logic                   up_dn,
  input  logic [NUM_DIG-1:0]     dp_in,
  output logic [4*NUM_DIG-1:0]   value,
  output logic [7:0]             seg,
  output logic [NUM_DIG-1:0]     dig
);

  localparam int unsigned VW = 4 * NUM_DIG;
  localparam int unsigned SW = $clog2(SCAN_DIV);
  localparam int unsigned CW = $clog2(CNT_DIV);
  localparam int unsigned IW = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;

  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CNT_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIG - 1);
  localparam logic [VW-1:0] ONE       = VW'(1);
  localparam logic          ACT_LOW   = (DIG_ACT_LOW != 0);
  localparam logic [NUM_DIG-1:0] DIG_OFF = {NUM_DIG{ACT_LOW}};

  logic [SW-1:0]      scan_cnt_q, scan_cnt_d;
  logic [IW-1:0]      scan_idx_q, scan_idx_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [VW-1:0]      value_q, value_d;
  logic [7:0]         seg_q, seg_d;
  logic [NUM_DIG-1:0] dig_q, dig_d;

  logic               step;
  logic [3:0]         nib;
  logic               dp_sel;
  logic               blank_sel;
  logic [NUM_DIG-1:0] dig_act;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'ha:    s = 7'h08;
      4'hb:    s = 7'h03;
      4'hc:    s = 7'h46;
      4'hd:    s = 7'h21;
      4'he:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Digit scan prescaler and index
  always_comb begin
    scan_cnt_d = scan_cnt_q + SW'(1);
    scan_idx_d = scan_idx_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = '0;
      scan_idx_d = (scan_idx_q == IDX_LAST) ? '0
                 : scan_idx_q + IW'(1);
    end
  end

  // Count prescaler and value register; load beats a coincident step
  assign step = cnt_en && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d   = cnt_q;
    value_d = value_q;
    if (load) begin
      cnt_d   = '0;
      value_d = load_val;
    end else if (cnt_en) begin
      if (step) begin
        cnt_d   = '0;
        value_d = up_dn ? value_q - ONE
                        : value_q + ONE;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

`ifdef SLED_LZB_EN
  // blank[k]: nibble k and everything above it are zero (k>0)
  logic [NUM_DIG-1:0] blank;
  logic               zero_above;

  always_comb begin
    zero_above = 1'b1;
    blank      = '0;
    for (int k = NUM_DIG - 1; k > 0; k--) begin
      zero_above = zero_above
                && (value_q[4*k +: 4] == 4'h0);
      blank[k]   = zero_above;
    end
  end
`endif

  // Select the active digit's nibble and dp
  always_comb begin
    nib       = 4'h0;
    dp_sel    = 1'b0;
    blank_sel = 1'b0;
    dig_act   = '0;
    for (int k = 0; k < NUM_DIG; k++) begin
      if (IW'(k) == scan_idx_q) begin
        nib        = value_q[4*k +: 4];
        dp_sel     = dp_in[k];
        dig_act[k] = 1'b1;
`ifdef SLED_LZB_EN
        blank_sel  = blank[k];
`endif
      end
    end
  end

  always_comb begin
    seg_d[7]   = ~dp_sel;
    seg_d[6:0] = blank_sel ? 7'h7F : hex7(nib);
    dig_d      = ACT_LOW ? ~dig_act : dig_act;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_q <= '0;
      scan_idx_q <= '0;
      cnt_q      <= '0;
      value_q    <= '0;
      seg_q      <= 8'hFF;
      dig_q      <= DIG_OFF;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      scan_idx_q <= scan_idx_d;
      cnt_q      <= cnt_d;
      value_q    <= value_d;
      seg_q      <= seg_d;
      dig_q      <= dig_d;
    end
  end

  assign value = value_q;
  assign seg   = seg_q;
  assign dig   = dig_q;

endmodule

// File: tb/tb_sled_scan.sv
// tb_sled_scan: directed bench for sled_scan (4 digits, fast dividers).
// Expected display/value results go through scoreboard queues.
module tb_sled_scan;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        load;
  logic [15:0] load_val;
  logic        cnt_en;
  logic        up_dn;
  logic [3:0]  dp_in;
  logic [15:0] value;
  logic [7:0]  seg;
  logic [3:0]  dig;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [15:0] vq[$];
  logic [11:0] sq[$];

  sled_scan #(
    .NUM_DIG(4),
    .SCAN_DIV(4),
    .CNT_DIV(8),
    .DIG_ACT_LOW(1)
  ) dut (
    .clock(clock),
    .rst_n(rst_n),
    .load(load),
    .load_val(load_val),
    .cnt_en(cnt_en),
    .up_dn(up_dn),
    .dp_in(dp_in),
    .value(value),
    .seg(seg),
    .dig(dig)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] hexbyte(input logic [3:0] n);
    logic [7:0] t[16];
    t = '{8'hc0, 8'hf9, 8'ha4, 8'hb0, 8'h99, 8'h92, 8'h82, 8'hf8,
          8'h80, 8'h90, 8'h88, 8'h83, 8'hc6, 8'ha1, 8'h86, 8'h8e};
    return t[n];
  endfunction

  function automatic logic [7:0] exp_seg(input logic [15:0] v,
                                         input logic [3:0] dp,
                                         input int d);
    logic [15:0] sh;
    logic [7:0]  b;
    sh = v >> (4 * d);
    b  = hexbyte(sh[3:0]);
`ifdef SLED_LZB_EN
    if (d > 0 && sh == 16'h0) b = 8'hFF;
`endif
    b[7] = ~dp[d];
    return b;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    cyc++;
  endtask

  task automatic chk_val(input string tag);
    logic [15:0] e;
    if (vq.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed empty queue expected entry", tag);
    end else begin
      e = vq.pop_front();
      chk(tag, value, e);
    end
  endtask

  // One upcoming edge per iteration: digit = (edge-1)/SCAN_DIV mod 4
  task automatic scan_check(input string tag, input int n,
                            input logic [15:0] v,
                            input logic [3:0] dp);
    int d;
    logic [3:0]  ed;
    logic [11:0] e;
    for (int i = 0; i < n; i++) begin
      d  = (cyc / 4) % 4;
      ed = ~(4'b0001 << d);
      sq.push_back({ed, exp_seg(v, dp, d)});
      tick();
      e = sq.pop_front();
      chk({tag, "_dig"}, {12'h0, dig}, {12'h0, e[11:8]});
      chk({tag, "_seg"}, {8'h0, seg}, {8'h0, e[7:0]});
    end
  endtask

  initial begin
    load = 1'b0; load_val = '0; cnt_en = 1'b0;
    up_dn = 1'b0; dp_in = '0;

    repeat (2) @(negedge clock);
    chk("rst_seg", {8'h0, seg}, 16'h00FF);
    chk("rst_dig", {12'h0, dig}, 16'h000F);
    chk("rst_val", value, 16'h0000);

    rst_n = 1'b1; load = 1'b1; load_val = 16'h00A7; cnt_en = 1'b1;
    @(negedge clock);
    load = 1'b0;
    chk("load_a7", value, 16'h00A7);
    repeat (3) @(negedge clock);
    chk("cnt_mid", value, 16'h00A7);

    // asynchronous reset in the middle of a cycle
    #2 rst_n = 1'b0;
    #1;
    chk("arst_seg", {8'h0, seg}, 16'h00FF);
    chk("arst_dig", {12'h0, dig}, 16'h000F);
    chk("arst_val", value, 16'h0000);
    @(negedge clock);

    rst_n = 1'b1; load = 1'b1; load_val = 16'h1234; cnt_en = 1'b0;
    cyc = 0;
    tick();
    load = 1'b0;
    chk("first_dig", {12'h0, dig}, 16'h000E);
    chk("first_seg", {8'h0, seg}, 16'h00C0);
    chk("load_1234", value, 16'h1234);
    scan_check("scan", 19, 16'h1234, 4'b0000);

    // up wrap
    load = 1'b1; load_val = 16'hFFFE; cnt_en = 1'b1; up_dn = 1'b0;
    vq.push_back(16'hFFFE);
    tick();
    load = 1'b0;
    chk_val("up_load");
    vq.push_back(16'hFFFE);
    repeat (7) tick();
    chk_val("up_pre");
    vq.push_back(16'hFFFF);
    tick();
    chk_val("up_ffff");
    vq.push_back(16'h0000);
    repeat (8) tick();
    chk_val("up_wrap");

    // down wrap with dp on digit 1
    load = 1'b1; load_val = 16'h0001; up_dn = 1'b1; dp_in = 4'b0010;
    vq.push_back(16'h0001);
    tick();
    load = 1'b0;
    chk_val("dn_load");
    vq.push_back(16'h0000);
    repeat (8) tick();
    chk_val("dn_zero");
    vq.push_back(16'hFFFF);
    repeat (8) tick();
    chk_val("dn_wrap");

    // pause mid-count, prescaler must hold
    repeat (3) tick();
    cnt_en = 1'b0;
    scan_check("dp", 16, 16'hFFFF, 4'b0010);
    vq.push_back(16'hFFFF);
    chk_val("hold");
    cnt_en = 1'b1;
    vq.push_back(16'hFFFF);
    repeat (4) tick();
    chk_val("resume_pre");
    vq.push_back(16'hFFFE);
    tick();
    chk_val("resume_step");

    // load coinciding with a step
    repeat (7) tick();
    load = 1'b1; load_val = 16'h0500; up_dn = 1'b0;
    vq.push_back(16'h0500);
    tick();
    load = 1'b0;
    chk_val("coll_load");
    vq.push_back(16'h0500);
    repeat (7) tick();
    chk_val("coll_pre");
    vq.push_back(16'h0501);
    tick();
    chk_val("coll_step");

    // leading zeros
    cnt_en = 1'b0; dp_in = 4'b0000;
    load = 1'b1; load_val = 16'h0050;
    tick();
    load = 1'b0;
    scan_check("lzb", 16, 16'h0050, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sled_scan.md
Name: sled_scan

Overview:
Parametrised multi-digit seven-segment driver with time-multiplexed digit scanning and a built-in hex up/down counter. It drives NUM_DIG common-anode digits through one shared active-low segment bus, selecting one digit at a time. A loadable internal value register is either displayed as-is or stepped at a programmable rate. It sits directly at the board I/O for the segment and digit pins.

Parameters:
NUM_DIG, 4, number of digits scanned; legal range 1..8.
SCAN_DIV, 50000, clock cycles per digit slot; minimum 2.
CNT_DIV, 25000000, clock cycles per counter step; minimum 2.
DIG_ACT_LOW, 1, 1 = dig lines active-low, 0 = active-high.

Ports:
clock  input  1  system clock; single clock domain.
rst_n  input  1  asynchronous active-low reset.
load  input  1  1-cycle strobe; value <= load_val.
load_val  input  4*NUM_DIG  value to load; nibble 0 = rightmost digit.
cnt_en  input  1  1 = counter steps on each count tick.
up_dn  input  1  0 = count up, 1 = count down.
dp_in  input  NUM_DIG  per-digit decimal point request, 1 = lit.
value  output  4*NUM_DIG  current value register.
seg  output  8  segment bus, active-low; bit7 = dp, bits6:0 = g..a.
dig  output  NUM_DIG  digit enables, one-hot active per DIG_ACT_LOW.

Behaviour:
- Reset (async, rst_n=0): value=0, scan_idx=0, both prescalers=0, seg=8'hFF, all dig inactive (all 1s when DIG_ACT_LOW=1). Outputs take reset values immediately, even mid-scan or mid-count.
- Scan prescaler: counts 0..SCAN_DIV-1. At the terminal count it wraps to 0 and scan_idx advances: 0,1,..,NUM_DIG-1, then 0.
- seg and dig are registered from scan_idx, value and dp_in with 1-cycle latency.
  - The first posedge after reset release drives digit 0.
  - Each digit is held for exactly SCAN_DIV cycles.
- dig: only bit scan_idx is active; all others are inactive.
- seg[6:0] decode of nibble value[4*scan_idx+3:4*scan_idx] (full seg byte, dp off):
  - 0=c0, 1=f9, 2=a4, 3=b0, 4=99, 5=92, 6=82, 7=f8
  - 8=80, 9=90, a=88, b=83, c=c6, d=a1, e=86, f=8e
  - seg[7] = ~dp_in[scan_idx].
- Count prescaler: counts 0..CNT_DIV-1 while cnt_en=1 and produces a 1-cycle step at the terminal count.
  - It holds its current count while cnt_en=0.
  - It clears to 0 on load.
- Step: if up_dn=0, value <= value+1; else value <= value-1. Arithmetic is modulo 16^NUM_DIG.
  - Up wrap: all-F -> 0.
  - Down wrap: 0 -> all-F.
- load has priority over a coincident step. The step is discarded, value=load_val, and the next step occurs a full CNT_DIV cycles of cnt_en=1 later.
- value is updated on the clock edge; the display reflects it in the next registered seg update for each digit.
- up_dn change takes effect at the next step; no prescaler reset.
- Scan timing is independent of load, cnt_en and up_dn.

Optional Feature:
Macro SLED_LZB_EN: leading-zero blanking.
- With the macro defined: a digit k>0 is blanked when its nibble and all more-significant nibbles are 0. Blanked means seg[6:0]=7'h7F, with dp still driven from dp_in. dig scanning is unchanged. Digit 0 is never blanked.
- Without the macro: all digits are always decoded, with no blanking logic present.

Test Plan:
Bench configuration: NUM_DIG=4, SCAN_DIV=4, CNT_DIV=8, DIG_ACT_LOW=1.
1. Reset: assert rst_n=0 mid-count with value=16'h00A7 -> same time step: seg=8'hFF, dig=4'b1111, value=0. After release, the first edge gives dig=4'b1110.
2. Scan: load 16'h1234, cnt_en=0, dp_in=0 -> repeating 4-cycle slots:
   - dig 1110/seg 99
   - dig 1101/seg b0
   - dig 1011/seg a4
   - dig 0111/seg f9
3. Up wrap: load 16'hFFFE, cnt_en=1, up_dn=0 -> value=FFFF after 8 cycles, 0000 after 16 cycles.
4. Down wrap and dp: load 16'h0001, up_dn=1, dp_in=4'b0010 -> value 0000, then FFFF at 8-cycle intervals. Digit 1 seg[7]=0; all other digits have seg[7]=1.
5. Collision: assert load (load_val=16'h0500) in the same cycle as a step -> value=0500, with no increment. The next step occurs exactly 8 cycles later, giving 0501.
6. Blanking: load 16'h0050.
   - With SLED_LZB_EN: digits 3 and 2 have seg=FF, digit 1 has seg=92, digit 0 has seg=c0.
   - Without it: digits 3 and 2 have seg=c0.
